fifo_axis_bridge: RTL and testbench

Parametrised bridge from a standard (non-FWFT, 1-cycle read latency) FIFO read port to an AXI4-Stream master. Sits between the sample/packet FIFOs and the downstream AXIS consumers, and generalises our earlier FIFO-to-stream adapter:
- configurable data and lane width, with optional lane reversal;
- a 2-entry output buffer that sustains one beat per cycle under back-pressure;
- synchronous flush;
- optional fixed-length packet framing on `tlast`.

---
 rtl/fifo_axis_pkg.sv | 15 +
 rtl/axis_skid_buf2.sv | 32 +++
 rtl/fifo_axis_bridge.sv | 57 +++++
 tb/tb_fifo_axis_bridge.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_axis_pkg.sv
// fifo_axis_pkg: shared buffer depth, occupancy type and lane-reverse helper for the FIFO-to-AXIS bridge
package fifo_axis_pkg;
  localparam int BUF_DEPTH = 2;
  localparam int MAX_W = 1024;
  typedef logic [1:0] occ_t;
  function automatic logic [MAX_W-1:0] lane_swap(input logic [MAX_W-1:0] data, input int data_w, input int lane_w);
    logic [MAX_W-1:0] r;
    int n;
    r = '0;
    n = data_w / lane_w;
    for (int i = 0; i < MAX_W; i++)
      if (i < data_w) r[i] = data[10'((n - 1 - i / lane_w) * lane_w + i % lane_w)];
    return r;
  endfunction
endpackage

// File: rtl/axis_skid_buf2.sv
// axis_skid_buf2: two-entry in-order register buffer whose head feeds the stream directly
module axis_skid_buf2
  import fifo_axis_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output occ_t              occ
);
  logic [DATA_W-1:0] tail;
  // head shifts from tail on pop; a new word lands in the first free slot after any pop
  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      occ <= occ + occ_t'(push) - occ_t'(pop);
      if (pop && occ == occ_t'(BUF_DEPTH)) head <= tail;
      else if (push && (occ == '0 || pop)) head <= din;
      if (push && occ == (pop ? occ_t'(BUF_DEPTH) : 2'd1)) tail <= din;
    end
  end
endmodule

// File: rtl/fifo_axis_bridge.sv
// fifo_axis_bridge: non-FWFT FIFO read port to AXI4-Stream master; FIFO_AXIS_BRIDGE_TLAST_EN enables fixed-length tlast framing
module fifo_axis_bridge
  import fifo_axis_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int LANE_W     = 32,
  parameter int SWAP_LANES = 1,
  parameter int PKT_LEN    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_q,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic [1:0]        occupancy
);
  logic pend, pop;
  occ_t occ;
  logic [DATA_W-1:0] din;
  assign pop = m_tvalid & m_tready;
  assign m_tvalid = occ != '0;
  assign occupancy = occ;
  assign fifo_rd_en = ~rst & ~fifo_empty & ~flush & ((3'(occ) + 3'(pend) - 3'(pop)) < 3'(BUF_DEPTH));
  assign din = (SWAP_LANES != 0) ? DATA_W'(lane_swap(MAX_W'(fifo_q), DATA_W, LANE_W)) : fifo_q;
  // a read issued this cycle delivers data next cycle; flush drops that landing word
  always_ff @(posedge clk) begin
    pend <= (rst | flush) ? 1'b0 : fifo_rd_en;
  end
  axis_skid_buf2 #(.DATA_W(DATA_W)) u_buf (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .push (pend & ~flush),
    .din  (din),
    .pop  (pop),
    .head (m_tdata),
    .occ  (occ)
  );
`ifdef FIFO_AXIS_BRIDGE_TLAST_EN
  localparam int CW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 1);
  logic [CW-1:0] count;
  // beat position within the current packet, advanced on each transfer
  always_ff @(posedge clk) begin
    if (rst || flush) count <= '0;
    else if (pop) count <= (count == LAST) ? '0 : count + 1'b1;
  end
  assign m_tlast = m_tvalid & (count == LAST);
`else
  assign m_tlast = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_axis_bridge.sv
// tb_fifo_axis_bridge: directed table plus corner-case sequences for the FIFO-to-AXIS bridge
module tb_fifo_axis_bridge;
  localparam int PKT = 4;
  logic clk = 0, rst = 1, flush = 0, fifo_empty, fifo_rd_en, m_tvalid, m_tready = 0, m_tlast;
  logic [127:0] fifo_q = '0, m_tdata;
  logic [1:0] occupancy;
  int rd_ptr = 0, wr_ptr = 0, exp_idx = 0, beat_cnt = 0, tlast_seen = 0;
  int tests = 0, fails = 0;
  logic pv = 0, pl = 0;
  logic [127:0] pd = '0;

  typedef struct {
    int add;
    logic ready;
    logic flush;
    logic rd_en;
    logic valid;
    logic [1:0] occ;
  } vec_t;
  vec_t v[22];

  always #5 clk = ~clk;

  fifo_axis_bridge #(.DATA_W(128), .LANE_W(32), .SWAP_LANES(1), .PKT_LEN(PKT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_q(fifo_q), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tlast(m_tlast), .occupancy(occupancy)
  );

  function automatic logic [127:0] word(input int k);
    return {32'(4 * k + 3), 32'(4 * k + 2), 32'(4 * k + 1), 32'(4 * k)};
  endfunction

  function automatic logic [127:0] exp_swap(input logic [127:0] w);
    return {w[31:0], w[63:32], w[95:64], w[127:96]};
  endfunction

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idx(input int target, input int budget, input string name);
    int n = 0;
    while (exp_idx < target && n < budget) begin
      step();
      n++;
    end
    chk(name, exp_idx, target);
  endtask

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk)
    if (fifo_rd_en) begin
      fifo_q <= word(rd_ptr);
      rd_ptr <= rd_ptr + 1;
    end

  always @(negedge clk) begin
    if (rst) begin
      beat_cnt = 0;
      pv = 0;
    end else begin
      if (pv) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_data", m_tdata, pd);
        chk("hold_last", m_tlast, pl);
      end
      if (m_tvalid && m_tready) begin
        chk("beat_data", m_tdata, exp_swap(word(exp_idx)));
`ifdef FIFO_AXIS_BRIDGE_TLAST_EN
        chk("beat_last", m_tlast, (beat_cnt % PKT) == PKT - 1);
`else
        chk("beat_last", m_tlast, 0);
`endif
        if (m_tlast) tlast_seen++;
        exp_idx++;
        beat_cnt++;
      end
      pv = m_tvalid & ~m_tready & ~flush;
      pd = m_tdata;
      pl = m_tlast;
      if (flush) beat_cnt = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, r0, tl0, target, n;
    v[0] = '{1, 1, 0, 1, 0, 0};
    v[1] = '{0, 1, 0, 0, 0, 0};
    v[2] = '{0, 1, 0, 0, 1, 1};
    v[3] = '{8, 0, 0, 1, 0, 0};
    v[4] = '{0, 0, 0, 1, 0, 0};
    v[5] = '{0, 0, 0, 0, 1, 1};
    for (int i = 6; i <= 12; i++) v[i] = '{0, 0, 0, 0, 1, 2};
    v[13] = '{0, 1, 0, 1, 1, 2};
    for (int i = 14; i <= 18; i++) v[i] = '{0, 1, 0, 1, 1, 1};
    v[19] = '{0, 1, 0, 0, 1, 1};
    v[20] = '{0, 1, 0, 0, 1, 1};
    v[21] = '{0, 1, 0, 0, 0, 0};
    step();
    @(negedge clk);
    chk("rst_valid", m_tvalid, 0);
    chk("rst_data", m_tdata, 0);
    chk("rst_last", m_tlast, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    step();
    rst = 0;
    for (int i = 0; i < 22; i++) begin
      wr_ptr += v[i].add;
      m_tready = v[i].ready;
      flush = v[i].flush;
      @(negedge clk);
      chk($sformatf("vec%0d_rd_en", i), fifo_rd_en, v[i].rd_en);
      chk($sformatf("vec%0d_valid", i), m_tvalid, v[i].valid);
      chk($sformatf("vec%0d_occ", i), occupancy, v[i].occ);
      if (i == 2) chk("first_beat", m_tdata, 128'h00000000_00000001_00000002_00000003);
      step();
    end
    chk("table_beats", exp_idx, 9);
    target = exp_idx + 1000;
    wr_ptr += 1000;
    n = 0;
    while (exp_idx < target && n < 20000) begin
      m_tready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk("random_count", exp_idx, target);
    chk("random_no_dup", m_tvalid, 0);
    m_tready = 0;
    f0 = wr_ptr;
    wr_ptr += 3;
    @(negedge clk);
    chk("fl_rd_a", fifo_rd_en, 1);
    step();
    @(negedge clk);
    chk("fl_rd_b", fifo_rd_en, 1);
    chk("fl_occ_b", occupancy, 0);
    step();
    m_tready = 1;
    flush = 1;
    @(negedge clk);
    chk("fl_occ_c", occupancy, 1);
    chk("fl_rd_low", fifo_rd_en, 0);
    step();
    m_tready = 0;
    flush = 0;
    @(negedge clk);
    chk("fl_valid_d", m_tvalid, 0);
    chk("fl_occ_d", occupancy, 0);
    chk("fl_rd_d", fifo_rd_en, 1);
    chk("fl_popped", exp_idx, f0 + 1);
    exp_idx = f0 + 2;
    step();
    m_tready = 1;
    wait_idx(f0 + 3, 20, "flush_next_word");
    m_tready = 0;
    r0 = wr_ptr;
    wr_ptr += 1;
    step();
    step();
    rst = 1;
    wr_ptr += 1;
    @(negedge clk);
    chk("mr_occ_pre", occupancy, 1);
    chk("mr_rd_en", fifo_rd_en, 0);
    step();
    rst = 0;
    @(negedge clk);
    chk("mr_valid", m_tvalid, 0);
    chk("mr_data", m_tdata, 0);
    chk("mr_last", m_tlast, 0);
    chk("mr_occ", occupancy, 0);
    chk("mr_rd_en_after", fifo_rd_en, 1);
    exp_idx = r0 + 1;
    step();
    m_tready = 1;
    wait_idx(r0 + 2, 20, "rst_restart");
    rst = 1;
    step();
    rst = 0;
    tl0 = wr_ptr;
    exp_idx = tl0;
    tlast_seen = 0;
    wr_ptr += 12;
    wait_idx(tl0 + 12, 60, "tlast_beats");
`ifdef FIFO_AXIS_BRIDGE_TLAST_EN
    chk("tlast_count", tlast_seen, 3);
`else
    chk("tlast_count", tlast_seen, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
